// File: rtl/frogger_game_ctrl_pkg.sv
// Shared constants for the Frogger game core: phase encodings, button bit order and
// the direction priority picker used by the controller, renderer and score display.
package frogger_game_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPlay  = 2'd1,
    StDying = 2'd2,
    StOver  = 2'd3
  } game_state_e;

  typedef enum logic [2:0] {
    DirNone,
    DirUp,
    DirDn,
    DirLt,
    DirRt
  } dir_e;

  // Bit positions inside the packed button/event vector.
  localparam int unsigned BtnUp    = 0;
  localparam int unsigned BtnDn    = 1;
  localparam int unsigned BtnLt    = 2;
  localparam int unsigned BtnRt    = 3;
  localparam int unsigned BtnStart = 4;
  localparam int unsigned NumBtn   = 5;

  localparam int unsigned TimerW = 8;

  // Up > Dn > Lt > Rt; lower-priority events in the same cycle are dropped.
  function automatic dir_e pick_dir(input logic [3:0] ev);
    if (ev[BtnUp]) return DirUp;
    if (ev[BtnDn]) return DirDn;
    if (ev[BtnLt]) return DirLt;
    if (ev[BtnRt]) return DirRt;
    return DirNone;
  endfunction

endpackage

// File: rtl/frogger_game_ctrl_if.sv
// Switch-side inputs and renderer-side outputs of the game core, bundled as one bus.
interface frogger_game_ctrl_if #(
  parameter int unsigned GRID_COLS = 20,
  parameter int unsigned GRID_ROWS = 15,
  parameter int unsigned LIVES     = 3,
  parameter int unsigned SCORE_W   = 7
);
  localparam int unsigned XW = $clog2(GRID_COLS);
  localparam int unsigned YW = $clog2(GRID_ROWS);
  localparam int unsigned LW = $clog2(LIVES + 1);

  logic               i_Frame_Tick;
  logic               i_Up;
  logic               i_Dn;
  logic               i_Lt;
  logic               i_Rt;
  logic               i_Start;
  logic               i_Collision;
  logic [XW-1:0]      o_Frog_X;
  logic [YW-1:0]      o_Frog_Y;
  logic               o_Draw_Frog;
  logic [SCORE_W-1:0] o_Score;
  logic [LW-1:0]      o_Lives;
  logic [1:0]         o_State;

  modport master (
    output i_Frame_Tick, i_Up, i_Dn, i_Lt, i_Rt, i_Start, i_Collision,
    input  o_Frog_X, o_Frog_Y, o_Draw_Frog, o_Score, o_Lives, o_State
  );

  modport slave (
    input  i_Frame_Tick, i_Up, i_Dn, i_Lt, i_Rt, i_Start, i_Collision,
    output o_Frog_X, o_Frog_Y, o_Draw_Frog, o_Score, o_Lives, o_State
  );
endinterface

// File: rtl/frogger_game_ctrl_edge_pulse.sv
// Rising-edge detector. History resets to all-ones so a level held through reset
// never produces an event on release.
module frogger_game_ctrl_edge_pulse #(
  parameter int unsigned Width = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] level,
  output logic [Width-1:0] pulse
);
  logic [Width-1:0] hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= '1;
    else        hist_q <= level;
  end

  assign pulse = level & ~hist_q;
endmodule

// File: rtl/frogger_game_ctrl.sv
// Frogger game core: frog position, score, lives and the IDLE/PLAY/DYING/OVER phase FSM.
module frogger_game_ctrl
  import frogger_game_ctrl_pkg::*;
#(
  parameter int unsigned GRID_COLS      = 20,
  parameter int unsigned GRID_ROWS      = 15,
  parameter int unsigned START_COL      = 9,
  parameter int unsigned LIVES          = 3,
  parameter int unsigned SCORE_W        = 7,
  parameter int unsigned RESPAWN_FRAMES = 60
) (
  input logic                i_Clk,
  input logic                i_Rst_L,
  frogger_game_ctrl_if.slave bus
);
  localparam int unsigned XW = $clog2(GRID_COLS);
  localparam int unsigned YW = $clog2(GRID_ROWS);
  localparam int unsigned LW = $clog2(LIVES + 1);

  localparam logic [XW-1:0]      SpawnX    = XW'(START_COL);
  localparam logic [YW-1:0]      SpawnY    = YW'(GRID_ROWS - 1);
  localparam logic [XW-1:0]      MaxX      = XW'(GRID_COLS - 1);
  localparam logic [LW-1:0]      FullLives = LW'(LIVES);
  localparam logic [SCORE_W-1:0] MaxScore  = '1;
  localparam logic [TimerW-1:0]  TimerInit = TimerW'(RESPAWN_FRAMES);

  game_state_e        state_q, state_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LW-1:0]      lives_q, lives_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic               draw_q, draw_d;
  logic [NumBtn-1:0]  ev;
  dir_e               dir;

  frogger_game_ctrl_edge_pulse #(
    .Width(NumBtn)
  ) u_edge (
    .clk  (i_Clk),
    .rst_n(i_Rst_L),
    .level({bus.i_Start, bus.i_Rt, bus.i_Lt, bus.i_Dn, bus.i_Up}),
    .pulse(ev)
  );

  assign dir = pick_dir(ev[3:0]);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    score_d = score_q;
    lives_d = lives_q;
    timer_d = timer_q;
    draw_d  = draw_q;
    unique case (state_q)
      StIdle, StOver: begin
        if (ev[BtnStart]) begin
          state_d = StPlay;
          score_d = '0;
          lives_d = FullLives;
          x_d     = SpawnX;
          y_d     = SpawnY;
          draw_d  = 1'b1;
        end
      end
      StPlay: begin
        // A qualified collision wins over any move in the same cycle.
        if (bus.i_Collision && bus.i_Frame_Tick && lives_q != '0) begin
          state_d = StDying;
          lives_d = lives_q - LW'(1);
          timer_d = TimerInit;
          draw_d  = TimerInit[2];
        end else begin
          unique case (dir)
            DirUp: begin
              if (y_q == YW'(1)) begin
                if (score_q != MaxScore) score_d = score_q + SCORE_W'(1);
                x_d = SpawnX;
                y_d = SpawnY;
              end else begin
                y_d = y_q - YW'(1);
              end
            end
            DirDn:   if (y_q != SpawnY) y_d = y_q + YW'(1);
            DirLt:   if (x_q != '0) x_d = x_q - XW'(1);
            DirRt:   if (x_q != MaxX) x_d = x_q + XW'(1);
            default: ;
          endcase
        end
      end
      StDying: begin
        if (timer_q == '0) begin
          if (lives_q == '0) begin
            state_d = StOver;
            draw_d  = 1'b0;
          end else begin
            state_d = StPlay;
            x_d     = SpawnX;
            y_d     = SpawnY;
            draw_d  = 1'b1;
          end
        end else if (bus.i_Frame_Tick) begin
          timer_d = timer_q - TimerW'(1);
          draw_d  = timer_d[2];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= StIdle;
      x_q     <= SpawnX;
      y_q     <= SpawnY;
      score_q <= '0;
      lives_q <= FullLives;
      timer_q <= '0;
      draw_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      score_q <= score_d;
      lives_q <= lives_d;
      timer_q <= timer_d;
      draw_q  <= draw_d;
    end
  end

  assign bus.o_State     = state_q;
  assign bus.o_Frog_X    = x_q;
  assign bus.o_Frog_Y    = y_q;
  assign bus.o_Score     = score_q;
  assign bus.o_Lives     = lives_q;
  assign bus.o_Draw_Frog = draw_q;
endmodule

// File: tb/tb_frogger_game_ctrl.sv
// Directed bench: stimulus pushes hand-computed expected outputs tagged with the cycle
// they are due; a negedge monitor pops and compares them.
module tb_frogger_game_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  frogger_game_ctrl_if #(
    .GRID_COLS(20), .GRID_ROWS(15), .LIVES(3), .SCORE_W(7)
  ) bus ();

  frogger_game_ctrl #(
    .GRID_COLS(20), .GRID_ROWS(15), .START_COL(9), .LIVES(3), .SCORE_W(7),
    .RESPAWN_FRAMES(60)
  ) dut (
    .i_Clk  (clk),
    .i_Rst_L(rst_n),
    .bus    (bus)
  );

  localparam logic [4:0] BNone  = 5'b00000;
  localparam logic [4:0] BUp    = 5'b00001;
  localparam logic [4:0] BDn    = 5'b00010;
  localparam logic [4:0] BLt    = 5'b00100;
  localparam logic [4:0] BRt    = 5'b01000;
  localparam logic [4:0] BStart = 5'b10000;

  typedef struct {
    string      name;
    int         due;
    logic [1:0] st;
    logic [4:0] x;
    logic [3:0] y;
    logic [6:0] score;
    logic [1:0] lives;
    logic       draw;
    bit         chk_pos;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [1:0] e_st;
  logic [4:0] e_x;
  logic [3:0] e_y;
  logic [6:0] e_score;
  logic [1:0] e_lives;
  logic       e_draw;
  bit         e_chk_pos;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      n_checks++;
      if (mon_e.due != cyc || bus.o_State !== mon_e.st || bus.o_Score !== mon_e.score ||
          bus.o_Lives !== mon_e.lives || bus.o_Draw_Frog !== mon_e.draw ||
          (mon_e.chk_pos && (bus.o_Frog_X !== mon_e.x || bus.o_Frog_Y !== mon_e.y))) begin
        n_errors++;
        $display("FAIL %s @cyc %0d (due %0d): got st=%0d x=%0d y=%0d score=%0d lives=%0d draw=%0d, want st=%0d x=%0d y=%0d score=%0d lives=%0d draw=%0d%s",
                 mon_e.name, cyc, mon_e.due, bus.o_State, bus.o_Frog_X, bus.o_Frog_Y,
                 bus.o_Score, bus.o_Lives, bus.o_Draw_Frog, mon_e.st, mon_e.x, mon_e.y,
                 mon_e.score, mon_e.lives, mon_e.draw, mon_e.chk_pos ? "" : " (pos ignored)");
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input string name, input int due);
    exp_t e;
    e.name = name; e.due = due; e.st = e_st; e.x = e_x; e.y = e_y;
    e.score = e_score; e.lives = e_lives; e.draw = e_draw; e.chk_pos = e_chk_pos;
    sb.push_back(e);
  endtask

  task automatic set_in(input logic [4:0] btn, input logic coll, input logic ft);
    bus.i_Up = btn[0]; bus.i_Dn = btn[1]; bus.i_Lt = btn[2]; bus.i_Rt = btn[3];
    bus.i_Start = btn[4]; bus.i_Collision = coll; bus.i_Frame_Tick = ft;
  endtask

  // One-cycle input pulse followed by one idle cycle; result is due one cycle later.
  task automatic pulse(input logic [4:0] btn, input logic coll, input logic ft,
                       input string name, input bit chk);
    set_in(btn, coll, ft);
    if (chk) push_exp(name, cyc + 1);
    tick();
    set_in(BNone, 1'b0, 1'b0);
    tick();
  endtask

  task automatic set_exp(input logic [1:0] st, input logic [4:0] x, input logic [3:0] y,
                         input logic [6:0] score, input logic [1:0] lives, input logic d);
    e_st = st; e_x = x; e_y = y; e_score = score; e_lives = lives; e_draw = d;
    e_chk_pos = 1'b1;
  endtask

  // 60 frame ticks in DYING; draw follows bit 2 of the remaining frame count.
  task automatic die_wait(input bit chk);
    int rem;
    for (int k = 1; k <= 60; k++) begin
      rem = 60 - k;
      e_draw = rem[2];
      pulse((k == 5) ? (BUp | BStart) : BNone, 1'b0, 1'b1, "dying_tick", chk);
    end
  endtask

  initial begin
    set_in(BNone, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    tick();
    set_exp(2'd0, 5'd9, 4'd14, 7'd0, 2'd3, 1'b1);
    push_exp("reset_defaults", cyc);
    tick();
    rst_n = 1'b1;
    tick();
    pulse(BNone, 1'b0, 1'b0, "idle_hold", 1'b1);

    set_exp(2'd1, 5'd9, 4'd14, 7'd0, 2'd3, 1'b1);
    pulse(BStart, 1'b0, 1'b0, "start", 1'b1);

    // First goal: every step checked.
    for (int i = 1; i <= 13; i++) begin
      e_y = 4'(14 - i);
      pulse(BUp, 1'b0, 1'b0, "up_step", 1'b1);
    end
    e_y = 4'd14; e_score = 7'd1;
    pulse(BUp, 1'b0, 1'b0, "goal_1", 1'b1);

    // Goals 2..128: score saturates at 127.
    for (int g = 2; g <= 128; g++) begin
      for (int i = 0; i < 13; i++) pulse(BUp, 1'b0, 1'b0, "", 1'b0);
      e_score = (g > 127) ? 7'd127 : 7'(g);
      pulse(BUp, 1'b0, 1'b0, (g > 127) ? "score_saturate" : "goal", 1'b1);
    end

    // Held Lt moves once.
    set_in(BLt, 1'b0, 1'b0);
    e_x = 5'd8;
    push_exp("lt_held_first", cyc + 1);
    tick();
    for (int i = 0; i < 28; i++) tick();
    push_exp("lt_held_no_repeat", cyc + 1);
    tick();
    set_in(BNone, 1'b0, 1'b0);
    tick();
    for (int i = 7; i >= 0; i--) begin
      e_x = 5'(i);
      pulse(BLt, 1'b0, 1'b0, "lt_step", 1'b1);
    end
    pulse(BLt, 1'b0, 1'b0, "lt_clamp", 1'b1);
    for (int i = 1; i <= 19; i++) begin
      e_x = 5'(i);
      pulse(BRt, 1'b0, 1'b0, "rt_step", 1'b1);
    end
    pulse(BRt, 1'b0, 1'b0, "rt_clamp", 1'b1);
    e_x = 5'd18;
    pulse(BLt | BRt, 1'b0, 1'b0, "lt_over_rt", 1'b1);
    pulse(BDn | BLt, 1'b0, 1'b0, "dn_clamp_drops_lt", 1'b1);
    e_y = 4'd13;
    pulse(BUp | BRt, 1'b0, 1'b0, "up_over_rt", 1'b1);
    e_y = 4'd14;
    pulse(BDn, 1'b0, 1'b0, "dn_step", 1'b1);
    e_y = 4'd13;
    pulse(BUp, 1'b0, 1'b0, "up_pre_collide", 1'b1);

    // Collision beats simultaneous Up; then blink through DYING and respawn.
    e_st = 2'd2; e_lives = 2'd2; e_draw = 1'b1;
    pulse(BUp, 1'b1, 1'b1, "collide_over_up", 1'b1);
    die_wait(1'b1);
    set_exp(2'd1, 5'd9, 4'd14, 7'd127, 2'd2, 1'b1);
    push_exp("respawn", cyc);

    e_y = 4'd13;
    pulse(BUp, 1'b0, 1'b0, "up_after_respawn", 1'b1);
    pulse(BStart, 1'b0, 1'b0, "start_ignored_in_play", 1'b1);
    pulse(BNone, 1'b1, 1'b0, "collision_needs_tick", 1'b1);

    e_st = 2'd2; e_lives = 2'd1; e_draw = 1'b1;
    pulse(BNone, 1'b1, 1'b1, "collide_2", 1'b1);
    die_wait(1'b0);
    set_exp(2'd1, 5'd9, 4'd14, 7'd127, 2'd1, 1'b1);
    push_exp("respawn_2", cyc);

    e_st = 2'd2; e_lives = 2'd0; e_draw = 1'b1;
    pulse(BNone, 1'b1, 1'b1, "collide_3", 1'b1);
    die_wait(1'b0);
    e_st = 2'd3; e_draw = 1'b0; e_chk_pos = 1'b0;
    push_exp("game_over", cyc);
    pulse(BUp, 1'b1, 1'b1, "over_hold", 1'b1);

    set_exp(2'd1, 5'd9, 4'd14, 7'd0, 2'd3, 1'b1);
    pulse(BStart, 1'b0, 1'b0, "restart_from_over", 1'b1);

    // Asynchronous reset mid-DYING, with Up and Start held through release.
    e_y = 4'd13;
    pulse(BUp, 1'b0, 1'b0, "up_before_reset", 1'b1);
    e_st = 2'd2; e_lives = 2'd2;
    pulse(BNone, 1'b1, 1'b1, "collide_before_reset", 1'b1);
    for (int i = 0; i < 3; i++) pulse(BNone, 1'b0, 1'b1, "", 1'b0);
    rst_n = 1'b0;
    set_in(BUp | BStart, 1'b0, 1'b0);
    set_exp(2'd0, 5'd9, 4'd14, 7'd0, 2'd3, 1'b1);
    push_exp("async_reset_immediate", cyc);
    tick();
    tick();
    rst_n = 1'b1;
    push_exp("held_through_reset_1", cyc + 1);
    tick();
    push_exp("held_through_reset_2", cyc + 1);
    tick();
    set_in(BNone, 1'b0, 1'b0);
    tick();
    e_st = 2'd1;
    pulse(BStart, 1'b0, 1'b0, "start_after_reset", 1'b1);

    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      $display("FAIL drain: got %0d pending checks, want 0", sb.size());
      n_errors += sb.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/frogger_game_ctrl.md
Name: frogger_game_ctrl

Overview:
- Parametrised game-control core for the Frogger VGA design.
- Owns frog grid position, score, lives and game-phase state machine, generalised over grid size, lives and score width.
- Sits between the debounced switch inputs and the sprite/VGA renderer.
- Adds start/game-over flow, collision handling, a respawn blink and goal scoring, none of which the current top-level has.

Parameters:
- GRID_COLS, 20, number of frog columns (X range 0..GRID_COLS-1)
- GRID_ROWS, 15, number of frog rows (Y range 0..GRID_ROWS-1; row 0 is goal)
- START_COL, 9, spawn column; spawn row is always GRID_ROWS-1
- LIVES, 3, lives per game (1..15)
- SCORE_W, 7, score width; score saturates at 2^SCORE_W-1
- RESPAWN_FRAMES, 60, frames spent in DYING (1..255)

Ports:
- i_Clk  in  1  system clock (25 MHz)
- i_Rst_L  in  1  asynchronous active-low reset
- i_Frame_Tick  in  1  one-cycle pulse per VGA frame
- i_Up  in  1  debounced level, active-high
- i_Dn  in  1  debounced level, active-high
- i_Lt  in  1  debounced level, active-high
- i_Rt  in  1  debounced level, active-high
- i_Start  in  1  debounced level, active-high
- i_Collision  in  1  frog/obstacle overlap flag from renderer; qualified by i_Frame_Tick
- o_Frog_X  out  $clog2(GRID_COLS)  frog column
- o_Frog_Y  out  $clog2(GRID_ROWS)  frog row
- o_Draw_Frog  out  1  sprite enable
- o_Score  out  SCORE_W  goals reached
- o_Lives  out  $clog2(LIVES+1)  remaining lives
- o_State  out  2  IDLE=0, PLAY=1, DYING=2, OVER=3

Behaviour:
- Reset (i_Rst_L low, asynchronous): state IDLE; X=START_COL; Y=GRID_ROWS-1; score 0; lives LIVES; timer 0; o_Draw_Frog 1.
- Reset also sets the edge-detect history to 1, so a button held through reset produces no event.
- All outputs are registered.
- Each event is a rising edge: level high now, low in previous cycle.
- An event updates outputs on the clock edge that first samples the input high (one cycle after the input changes).
- IDLE:
  - frog drawn at spawn.
  - Start event -> PLAY; score 0; lives LIVES; spawn position.
- PLAY moves:
  - At most one move per cycle; simultaneous direction events resolve with priority Up > Dn > Lt > Rt, and the others are dropped.
  - Moves clamp at grid borders (no wrap): Lt at X=0, Rt at X=GRID_COLS-1 and Dn at Y=GRID_ROWS-1 are no-ops.
  - Up from Y=1 is a goal: score +1 (saturating, no wrap) and frog placed at spawn in the same cycle. Y never reads 0.
- PLAY collision:
  - Condition: i_Collision && i_Frame_Tick.
  - Action: lives -1, timer loaded with RESPAWN_FRAMES, state -> DYING.
  - Collision has priority over a move in the same cycle; the move is discarded.
  - Frog position freezes at the collision point.
- DYING:
  - Direction and start events are ignored.
  - Timer decrements on each i_Frame_Tick.
  - o_Draw_Frog = timer bit 2 (blinks every 4 frames).
  - When timer reaches 0, on the next cycle:
    - lives==0 -> OVER with o_Draw_Frog 0.
    - otherwise -> PLAY at spawn with o_Draw_Frog 1.
- OVER: frog hidden; score and lives held; Start event -> PLAY with a fresh game.
- Start events in PLAY are ignored (no restart mid-game).
- Reset asserted mid-game returns to IDLE immediately and unconditionally.
- Lives never underflow; the DYING entry guard requires lives>0 in PLAY.

Decomposition:
- Shared constants package: state encodings (IDLE/PLAY/DYING/OVER) and direction priority order, reused by the renderer and the score display.
- One sub-module: edge_pulse, a parametrised-width rising-edge detector (width 5 here) with asynchronous active-low reset and history reset to all-ones.

Test Plan:
- Reset, then pulse i_Start -> o_State=1, X=9, Y=14, o_Lives=3, o_Score=0, o_Draw_Frog=1.
- 14 separate Up pulses from spawn -> 14th pulse gives o_Score=1, X=9, Y=14. Repeat 127 goals with SCORE_W=7 plus one more -> o_Score stays 127.
- Lt held across 30 cycles gives one move. Then 9 more Lt pulses then 1 Lt -> X stops at 0. Up+Rt rising in the same cycle -> only Y decrements.
- i_Collision high with frame tick while an Up event occurs -> o_State=2, o_Lives=2, Y unchanged. After 60 frame ticks -> o_State=1 at spawn. o_Draw_Frog toggles every 4 frames during DYING.
- Three collisions -> o_State=3, o_Lives=0, o_Draw_Frog=0. Start pulse -> o_State=1, lives 3, score 0.
- Assert i_Rst_L low asynchronously mid-DYING, and separately with i_Up held through reset release -> immediate IDLE defaults; no move on release.
